// File: rtl/mult_seq.sv
// Sequential unsigned shift-and-add multiplier: one M-bit ripple-carry adder
// (suma) is reused over M clock cycles to build a 2M-bit product.

module suma #(
  parameter int M = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         ci,
  output logic [M-1:0] s,
  output logic         co,
  output logic         n,
  output logic         v,
  output logic         z
);

  logic [M:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < M; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[M];
  assign n  = s[M-1];
  assign v  = c[M] ^ c[M-1];
  assign z  = ~|s;

endmodule

module mult_seq #(
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   A,
  input  logic [M-1:0]   B,
  output logic [2*M-1:0] P,
  output logic           busy,
  output logic           done,
  output logic           Z
);

  localparam int CW = (M > 2) ? $clog2(M) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(M - 1);

  logic [1:0]    state;
  logic [M-1:0]  mcand;
  logic [M-1:0]  acc;
  logic [M-1:0]  q;
  logic          cy;
  logic [CW-1:0] cnt;

  logic [M-1:0]  sum;
  logic          co;
  logic          add_n_unused;
  logic          add_v_unused;
  logic          add_z_unused;

  logic [2*M:0]  step;
  logic [2*M:0]  shifted;

  // cy is always cleared by the shift, so feeding it as carry-in keeps the
  // adder input well defined without changing the sum.
  suma #(.M(M)) u_suma (
    .a  (acc),
    .b  (mcand),
    .ci (cy),
    .s  (sum),
    .co (co),
    .n  (add_n_unused),
    .v  (add_v_unused),
    .z  (add_z_unused)
  );

  assign step    = q[0] ? {co, sum, q} : {1'b0, acc, q};
  assign shifted = step >> 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      q     <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      P     <= '0;
      Z     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= A;
            q     <= B;
            acc   <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          cy  <= shifted[2*M];
          acc <= shifted[2*M-1:M];
          q   <= shifted[M-1:0];
          cnt <= cnt + CW'(1);
          // P and Z are only ever loaded here, so they hold between operations.
          if (cnt == LAST) begin
            P     <= shifted[2*M-1:0];
            Z     <= (shifted[2*M-1:0] == '0);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Scoreboard bench for mult_seq at M=4 and M=8; expected products are queued
// on each accepting edge and popped when done is observed.

module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [7:0]  p4;
  logic [15:0] p8;
  logic        busy4, done4, z4;
  logic        busy8, done8, z8;

  typedef struct {
    string       tag;
    logic [15:0] p;
    logic        z;
  } expect_t;

  expect_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq #(.M(4)) dut4 (
    .clk(clk), .rst(rstN), .start(start4), .A(a4), .B(b4),
    .P(p4), .busy(busy4), .done(done4), .Z(z4)
  );

  mult_seq #(.M(8)) dut8 (
    .clk(clk), .rst(rstN), .start(start8), .A(a8), .B(b8),
    .P(p8), .busy(busy8), .done(done8), .Z(z8)
  );

  function automatic logic doneOf(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  function automatic logic busyOf(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic zOf(input int w);
    return (w == 4) ? z4 : z8;
  endfunction

  function automatic logic [15:0] pOf(input int w);
    return (w == 4) ? {8'h00, p4} : p8;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input int w, input logic [7:0] a, input logic [7:0] b);
    expect_t e;
    logic [15:0] prod;
    prod = {8'h00, a} * {8'h00, b};
    e.tag = $sformatf("m%0d %0dx%0d", w, a, b);
    e.p = prod;
    e.z = (prod == 16'd0);
    sb.push_back(e);
  endtask

  // Drives one request and returns right after the accepting edge.
  task automatic applyStimulus(input int w, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    if (w == 4) begin
      a4 = a[3:0];
      b4 = b[3:0];
      start4 = 1'b1;
    end else begin
      a8 = a;
      b8 = b;
      start8 = 1'b1;
    end
    @(posedge clk);
    pushExpect(w, a, b);
  endtask

  task automatic awaitResult(input int w);
    int k;
    int busyCnt;
    expect_t e;
    @(negedge clk);
    if (w == 4) start4 = 1'b0;
    else start8 = 1'b0;
    k = 0;
    busyCnt = 0;
    while (!doneOf(w) && k < 4 * w) begin
      if (busyOf(w)) busyCnt++;
      @(negedge clk);
      k++;
    end
    if (busyOf(w)) busyCnt++;
    checkOutput("done_seen", {15'd0, doneOf(w)}, 16'd1);
    checkOutput("latency", 16'(k), 16'(w));
    checkOutput("busy_cycles", 16'(busyCnt), 16'(w + 1));
    checkOutput("sb_nonempty", {15'd0, sb.size() != 0}, 16'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, " P"}, pOf(w), e.p);
      checkOutput({e.tag, " Z"}, {15'd0, zOf(w)}, {15'd0, e.z});
    end
    @(negedge clk);
    checkOutput("done_fall", {15'd0, doneOf(w)}, 16'd0);
    checkOutput("busy_fall", {15'd0, busyOf(w)}, 16'd0);
  endtask

  initial begin
    logic [7:0] corners [7];
    expect_t e;
    corners = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
    rstN = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #12;
    checkOutput("rst P4", {8'h00, p4}, 16'd0);
    checkOutput("rst Z4", {15'd0, z4}, 16'd0);
    checkOutput("rst busy4", {15'd0, busy4}, 16'd0);
    checkOutput("rst done4", {15'd0, done4}, 16'd0);
    checkOutput("rst P8", p8, 16'd0);
    checkOutput("rst Z8", {15'd0, z8}, 16'd0);
    checkOutput("rst busy8", {15'd0, busy8}, 16'd0);
    checkOutput("rst done8", {15'd0, done8}, 16'd0);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(4, 8'd3, 8'd5);   awaitResult(4);
    applyStimulus(4, 8'd15, 8'd15); awaitResult(4);
    applyStimulus(4, 8'd0, 8'd9);   awaitResult(4);
    applyStimulus(4, 8'd15, 8'd1);  awaitResult(4);
    applyStimulus(4, 8'd1, 8'd15);  awaitResult(4);

    // Abort at iteration 2; the queued expectation for it is discarded.
    applyStimulus(4, 8'd7, 8'd6);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("abort P", {8'h00, p4}, 16'd0);
    checkOutput("abort Z", {15'd0, z4}, 16'd0);
    checkOutput("abort busy", {15'd0, busy4}, 16'd0);
    checkOutput("abort done", {15'd0, done4}, 16'd0);
    void'(sb.pop_back());
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(4, 8'd7, 8'd6);   awaitResult(4);

    // start held high with operands scrambled every cycle
    @(negedge clk);
    start4 = 1'b1;
    a4 = 4'($urandom_range(0, 15));
    b4 = 4'($urandom_range(0, 15));
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      if (i % 6 == 0) pushExpect(4, {4'h0, a4}, {4'h0, b4});
      @(negedge clk);
      checkOutput("held done", {15'd0, done4}, {15'd0, (i % 6) == 4});
      if (i % 6 == 5) checkOutput("held busy", {15'd0, busy4}, 16'd0);
      if (i % 6 == 4 && sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, " held P"}, {8'h00, p4}, e.p);
        checkOutput({e.tag, " held Z"}, {15'd0, z4}, {15'd0, e.z});
      end
      a4 = 4'($urandom_range(0, 15));
      b4 = 4'($urandom_range(0, 15));
    end
    start4 = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        applyStimulus(8, corners[i], corners[j]);
        awaitResult(8);
      end
    end
    for (int n = 0; n < 120; n++) begin
      applyStimulus(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      awaitResult(8);
    end

    checkOutput("sb_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
